// File: rtl/iob_axistream_arbiter.sv
// Packet-granular round-robin arbiter merging N_INPUTS AXI-Stream sources onto one master.
// A grant is held from the first beat of a packet until its tlast beat is accepted.
module iob_axistream_arbiter #(
    parameter int N_INPUTS = 4,
    parameter int TDATA_W  = 8,
    parameter int CNT_W    = 16,
    parameter int GRANT_W  = $clog2(N_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [N_INPUTS*TDATA_W-1:0]   s_tdata,
    input  logic [N_INPUTS-1:0]           s_tvalid,
    input  logic [N_INPUTS-1:0]           s_tlast,
    output logic [N_INPUTS-1:0]           s_tready,
    output logic [TDATA_W-1:0]            m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [GRANT_W-1:0]            grant,
    output logic                          busy,
    output logic [CNT_W-1:0]              beat_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state_reg, state_next;
    logic [GRANT_W-1:0]   grant_reg, grant_next;
    logic [GRANT_W-1:0]   last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;

    logic [TDATA_W-1:0]   s_data_arr [N_INPUTS];
    logic [2*N_INPUTS-1:0] req_rot;
    logic [GRANT_W-1:0]   sel_idx;
    logic                 sel_found;
    logic                 xfer;
    logic                 accept;

    assign xfer = (state_reg == XFER);

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
            assign s_data_arr[gi] = s_tdata[gi*TDATA_W +: TDATA_W];
            assign s_tready[gi]   = xfer && (grant_reg == GRANT_W'(gi)) && m_tready;
        end
    endgenerate

    // Rotate requests so bit k is input (last_grant+1+k) mod N; the lowest set bit wins.
    always_comb begin
        req_rot   = {s_tvalid, s_tvalid} >> (int'(last_grant_reg) + 1);
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (!sel_found && req_rot[k]) begin
                sel_found = 1'b1;
                sel_idx   = GRANT_W'((int'(last_grant_reg) + 1 + k) % N_INPUTS);
            end
        end
    end

    assign m_tvalid = xfer && s_tvalid[grant_reg];
    assign m_tlast  = xfer && s_tlast[grant_reg];
    assign m_tdata  = xfer ? s_data_arr[grant_reg] : '0;
    assign accept   = m_tvalid && m_tready;

    assign grant    = grant_reg;
    assign busy     = xfer;
    assign beat_cnt = beat_cnt_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (en && sel_found) begin
                    grant_next    = sel_idx;
                    beat_cnt_next = '0;
                    state_next    = XFER;
                end
            end
            XFER: begin
                // en is deliberately ignored here: a started packet always completes.
                if (accept) begin
                    if (beat_cnt_reg != '1) begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                    if (s_tlast[grant_reg]) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GRANT_W'(N_INPUTS - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

endmodule

// File: tb/tb_iob_axistream_arbiter.sv
// Self-checking bench for iob_axistream_arbiter: a directed vector table, corner-case
// sequences and random traffic, all compared against an in-bench behavioural model.
module tb_iob_axistream_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N*W-1:0]  s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [W-1:0]    m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic [GW-1:0]   grant;
    logic            busy;
    logic [CW-1:0]   beat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_axistream_arbiter #(
        .N_INPUTS(N),
        .TDATA_W (W),
        .CNT_W   (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .s_tdata (s_tdata),
        .s_tvalid(s_tvalid),
        .s_tlast (s_tlast),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tlast (m_tlast),
        .m_tready(m_tready),
        .grant   (grant),
        .busy    (busy),
        .beat_cnt(beat_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit         md_busy;
    int         md_grant, md_lg, md_cnt;
    bit         acc_valid, pkt_end;
    int         acc_idx;
    logic [7:0] cap_tdata;

    task automatic model_reset();
        md_busy  = 1'b0;
        md_grant = 0;
        md_lg    = N - 1;
        md_cnt   = 0;
    endtask

    // One clock cycle: inputs already driven; compare at the falling edge, advance model.
    task automatic cyc();
        logic       e_mv, e_ml;
        logic [7:0] e_md;
        logic [3:0] e_sr;
        int         c;
        #4;
        e_mv = md_busy && s_tvalid[md_grant];
        e_ml = md_busy && s_tlast[md_grant];
        e_md = md_busy ? s_tdata[md_grant*8 +: 8] : 8'h00;
        e_sr = md_busy ? (4'(m_tready) << md_grant) : 4'h0;
        check("m_tvalid", m_tvalid, e_mv);
        check("m_tlast",  m_tlast,  e_ml);
        check("m_tdata",  m_tdata,  e_md);
        check("s_tready", s_tready, e_sr);
        check("grant",    grant,    md_grant);
        check("busy",     busy,     md_busy);
        check("beat_cnt", beat_cnt, md_cnt);
        cap_tdata = m_tdata;
        acc_valid = 1'b0;
        pkt_end   = 1'b0;
        if (!md_busy) begin
            if (en && s_tvalid != 0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (md_lg + k) % N;
                    if (!md_busy && s_tvalid[c]) begin
                        md_busy  = 1'b1;
                        md_grant = c;
                        md_cnt   = 0;
                    end
                end
            end
        end else if (s_tvalid[md_grant] && m_tready) begin
            acc_valid = 1'b1;
            acc_idx   = md_grant;
            md_cnt    = (md_cnt < (1 << CW) - 1) ? md_cnt + 1 : (1 << CW) - 1;
            if (s_tlast[md_grant]) begin
                pkt_end = 1'b1;
                md_lg   = md_grant;
                md_busy = 1'b0;
                $display("packet done: input %0d, beat_cnt %0d", md_grant, md_cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast",  m_tlast,  0);
        check("rst_m_tdata",  m_tdata,  0);
        check("rst_s_tready", s_tready, 0);
        check("rst_grant",    grant,    0);
        check("rst_busy",     busy,     0);
        check("rst_beat_cnt", beat_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        mr;
        logic        e_mv;
        logic [7:0]  e_md;
        logic        e_ml;
        logic [3:0]  e_sr;
        logic [1:0]  e_g;
        logic        e_b;
        logic [3:0]  e_c;
    } vec_t;

    vec_t vecs[15];

    int   sent[N];
    int   npk, rx, sent0, sent1;
    logic done;

    initial begin
        vecs[0]  = '{1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'd0};
        vecs[2]  = '{1'b1, 4'b0100, 4'b0000, 32'h00A2_0000, 1'b1, 1'b1, 8'hA2, 1'b0, 4'b0100, 2'd2, 1'b1, 4'd1};
        vecs[3]  = '{1'b1, 4'b0100, 4'b0100, 32'h00A3_0000, 1'b1, 1'b1, 8'hA3, 1'b1, 4'b0100, 2'd2, 1'b1, 4'd2};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd2, 1'b0, 4'd3};
        vecs[5]  = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd2, 1'b0, 4'd3};
        vecs[6]  = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b1, 8'h13, 1'b1, 4'b1000, 2'd3, 1'b1, 4'd0};
        vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd3, 1'b0, 4'd1};
        vecs[8]  = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b1, 8'h10, 1'b1, 4'b0001, 2'd0, 1'b1, 4'd0};
        vecs[9]  = '{1'b0, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd1};
        vecs[10] = '{1'b0, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd1};
        vecs[11] = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd0, 1'b0, 4'd1};
        vecs[12] = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b0, 1'b1, 8'h11, 1'b1, 4'b0000, 2'd1, 1'b1, 4'd0};
        vecs[13] = '{1'b1, 4'b1111, 4'b1111, 32'h1312_1110, 1'b1, 1'b1, 8'h11, 1'b1, 4'b0010, 2'd1, 1'b1, 4'd0};
        vecs[14] = '{1'b1, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 2'd1, 1'b0, 4'd1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            en       = vecs[i].en;
            s_tvalid = vecs[i].tv;
            s_tlast  = vecs[i].tl;
            s_tdata  = vecs[i].td;
            m_tready = vecs[i].mr;
            #4;
            check("vec_m_tvalid", m_tvalid, vecs[i].e_mv);
            check("vec_m_tdata",  m_tdata,  vecs[i].e_md);
            check("vec_m_tlast",  m_tlast,  vecs[i].e_ml);
            check("vec_s_tready", s_tready, vecs[i].e_sr);
            check("vec_grant",    grant,    vecs[i].e_g);
            check("vec_busy",     busy,     vecs[i].e_b);
            check("vec_beat_cnt", beat_cnt, vecs[i].e_c);
            $display("vec %0d: m_tvalid=%0b m_tdata=%02h grant=%0d busy=%0b beat_cnt=%0d",
                     i, m_tvalid, m_tdata, grant, busy, beat_cnt);
            @(posedge clk);
            #1;
        end

        // Round robin with all four inputs sending 2-beat packets continuously.
        do_reset();
        en = 1'b1; m_tready = 1'b1; s_tvalid = 4'hF; npk = 0;
        for (int i = 0; i < N; i++) sent[i] = 0;
        for (int c = 0; c < 30 && npk < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                s_tlast[i]       = (sent[i] == 1);
                s_tdata[i*8 +: 8] = 8'(16 * i + sent[i]);
            end
            cyc();
            if (acc_valid) sent[acc_idx] = pkt_end ? 0 : sent[acc_idx] + 1;
            if (pkt_end) begin
                check("rr_grant", grant, npk % N);
                npk++;
            end
        end
        check("rr_packets", npk, 8);

        // Input 1 with m_tready toggling and tvalid dropping mid-packet.
        do_reset();
        en = 1'b1; sent1 = 0; rx = 0; done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            m_tready    = (c < 8) ? ((c % 2) == 0) : 1'b1;
            s_tvalid[1] = (sent1 < 4) && !(c == 4 || c == 5);
            s_tvalid[0] = md_busy;
            s_tvalid[2] = md_busy;
            s_tvalid[3] = md_busy;
            s_tlast     = {2'b00, (sent1 == 3), 1'b0};
            s_tdata     = {8'hEE, 8'hEE, 8'h50 + 8'(sent1), 8'hEE};
            cyc();
            if (acc_valid) begin
                check("stall_data", cap_tdata, 32'h50 + rx);
                rx++;
                sent1++;
            end
            if (pkt_end) done = 1'b1;
        end
        check("stall_done", done, 1);
        check("stall_beat_cnt", beat_cnt, 4);

        // en low blocks grants; en dropped mid-packet does not abort it.
        do_reset();
        m_tready = 1'b1; s_tvalid = 4'hF; s_tlast = 4'b1110; s_tdata = 32'h4433_2200; en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("en_hold_busy", busy, 0);
        end
        en = 1'b1; sent0 = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            s_tlast[0]   = (sent0 == 4);
            s_tdata[7:0] = 8'h20 + 8'(sent0);
            cyc();
            if (acc_valid && acc_idx == 0) begin
                sent0++;
                en = 1'b0;
            end
            if (pkt_end) done = 1'b1;
        end
        check("en_done", done, 1);
        check("en_beat_cnt", beat_cnt, 5);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("en_block_busy", busy, 0);
        end
        en = 1'b1;
        cyc();
        check("en_regrant_busy", busy, 1);
        check("en_regrant_grant", grant, 1);

        // Reset asserted after beat 2 of a 4-beat packet from input 3.
        do_reset();
        en = 1'b1; m_tready = 1'b1; s_tvalid = 4'b1000; s_tlast = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            s_tdata = {8'h30 + 8'(c), 24'h0};
            cyc();
        end
        check("pre_rst_grant", grant, 3);
        check("pre_rst_beat_cnt", beat_cnt, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_s_tready", s_tready, 0);
        check("mid_rst_grant",    grant,    0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_busy",     busy,     0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        s_tvalid = 4'hF; s_tlast = 4'hF; s_tdata = 32'h6362_6160;
        cyc();
        check("post_rst_grant", grant, 0);
        cyc();

        // 2^CNT_W+5 beats in one packet saturate beat_cnt.
        do_reset();
        en = 1'b1; m_tready = 1'b1; s_tvalid = 4'b0001; sent0 = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            s_tlast[0]   = (sent0 == (1 << CW) + 4);
            s_tdata[7:0] = 8'(sent0);
            cyc();
            if (acc_valid) sent0++;
            if (pkt_end) done = 1'b1;
        end
        check("sat_done", done, 1);
        check("sat_beat_cnt", beat_cnt, 15);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            en       = ($urandom_range(0, 7) != 0);
            s_tvalid = 4'($urandom);
            s_tlast  = 4'($urandom & $urandom);
            s_tdata  = $urandom;
            m_tready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_axistream_arbiter.md
# iob_axistream_arbiter

Packet-granular round-robin arbiter that merges `N_INPUTS` AXI-Stream sources onto one AXI-Stream master. Its typical use is feeding a single `iob_axistream_out` core, or any single stream sink, from several producers. A grant is held from the first beat of a packet until the beat carrying `tlast` has been accepted, so packets never interleave on the output. Software-visible status (current grant, busy, per-packet beat count) is exported for the peripheral's register file.

## Interface
Parameters:
- `N_INPUTS`, 4: number of slave stream inputs (2..16).
- `TDATA_W`, 8: stream data width.
- `CNT_W`, 16: width of the beat counter (saturating).
- `GRANT_W`, `$clog2(N_INPUTS)`: grant index width (derived, not overridden).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; gates new grants only.
- `s_tdata`  in  N_INPUTS*TDATA_W  slave data; input i occupies bits [i*TDATA_W +: TDATA_W].
- `s_tvalid`  in  N_INPUTS  slave valid, one bit per input.
- `s_tlast`  in  N_INPUTS  slave last, one bit per input.
- `s_tready`  out  N_INPUTS  slave ready, one bit per input.
- `m_tdata`  out  TDATA_W  master data.
- `m_tvalid`  out  1  master valid.
- `m_tlast`  out  1  master last.
- `m_tready`  in  1  master ready.
- `grant`  out  GRANT_W  index of the input currently or last granted.
- `busy`  out  1  high while in XFER.
- `beat_cnt`  out  CNT_W  beats accepted in the current or last packet.

## Operation
The arbiter has two states, IDLE and XFER.

IDLE:
- `m_tvalid` is 0 and all `s_tready` bits are 0.
- If `en` is 1 and `s_tvalid` is not all zero, select the first input with valid high. The search starts at `last_grant+1` and wraps modulo `N_INPUTS`.
- Load `grant` with the selected index, clear `beat_cnt`, and go to XFER.

XFER:
- The granted input is passed through combinationally:
  - `m_tdata` = data of input `grant`.
  - `m_tvalid` = `s_tvalid[grant]`.
  - `m_tlast` = `s_tlast[grant]`.
  - `s_tready[grant]` = `m_tready`.
  - All other `s_tready` bits are 0.
- A beat is accepted when `m_tvalid & m_tready`. Each accepted beat increments `beat_cnt`, which saturates at 2^CNT_W-1.
- On an accepted beat with `m_tlast`=1: set `last_grant` = `grant` and go to IDLE.
- If the granted input drops `tvalid` mid-packet, the grant is held. Other inputs wait.
- A 0 on `en` during XFER does not abort the packet. It only blocks the next grant.

Boundary rules:
- Reset values: IDLE, `grant`=0, `last_grant`=N_INPUTS-1 (so input 0 has priority first), `beat_cnt`=0, `busy`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0.
- Reset asserted mid-packet returns the block to the reset state immediately. The partial packet is not completed, and sinks must tolerate the truncation.
- A single-beat packet (tlast on the first beat) is legal: one cycle in XFER, then IDLE.
- `m_tdata` and `m_tlast` are 0 in IDLE.
- `grant` and `beat_cnt` hold their values in IDLE for software readout.

## Timing
- Arbitration latency: a request seen in IDLE at edge k puts the block in XFER after edge k; the first beat can be accepted in cycle k+1.
- Inter-packet bubble: exactly one cycle (IDLE) between the `tlast` beat and the next packet's first beat, including back-to-back packets from the same input.
- Throughput: one beat per cycle within a packet while valid and ready are both high.
- No combinational path from `m_tready` to any `s_tvalid`. Paths exist from `m_tready` to `s_tready` and from `s_tvalid` to `m_tvalid`.
- `busy` equals (state==XFER) and is registered.

## Test plan
- Reset, then input 2 sends 3 beats {0xA1,0xA2,0xA3} with tlast on the last, `m_tready`=1 → `m_tdata` shows A1, A2, A3 in cycles 2..4 after the request; `grant`=2; `beat_cnt`=3; `busy` falls after the tlast beat.
- All 4 inputs request continuously with 2-beat packets → grant order 0,1,2,3,0…; exactly one idle cycle between packets; no interleaving.
- Input 1 granted; `m_tready` toggles 1,0,1,0 and `s_tvalid[1]` drops for 2 cycles mid-packet → data is held stable while stalled, no beats are lost or duplicated, other `s_tready` bits stay 0, and `beat_cnt` equals the number of beats sent.
- `en`=0 with pending requests → stays in IDLE with `m_tvalid`=0. `en` dropped during a 5-beat packet → all 5 beats complete, then no new grant until `en`=1.
- Assert `rst` after beat 2 of a 4-beat packet → next cycle `m_tvalid`=0, `s_tready`=0, `grant`=0, `beat_cnt`=0; after release, input 0 wins the first arbitration.
- 2^CNT_W+5 beats in one packet (CNT_W=4) → `beat_cnt` saturates at 15.
